// File: rtl/ubit_store.sv
// Per-line instruction/data used-bit store with a flush sequencer that walks every entry to zero.
// Optional per-entry parity checking is enabled by defining UBIT_PARITY_EN.
module ubit_store #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RESET_n,
    input  logic [ADDR_W-1:0] LA,
    input  logic              LOOKUP,
    input  logic              NUBI_n,
    input  logic              NUBD_n,
    input  logic              WCA_n,
    input  logic              FLUSH,
    output logic              OUBI,
    output logic              OUBD,
    output logic              BUSY,
    output logic              PERR
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
`ifdef UBIT_PARITY_EN
    localparam int unsigned EW = 3;
`else
    localparam int unsigned EW = 2;
`endif

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W-1:0] la_q;
    logic [EW-1:0]     mem [DEPTH];

    logic [1:0]        new_bits;
    logic [EW-1:0]     wr_word;
    logic [EW-1:0]     rd_word;
    logic              wr_en;
    logic              rd_en;
    logic              bypass;
    logic              par_err;

    always_comb begin
        new_bits = {~NUBI_n, ~NUBD_n};
        wr_en    = (state == IDLE) && !FLUSH && !WCA_n;
        rd_en    = (state == IDLE) && !FLUSH && LOOKUP;
        bypass   = wr_en && (LA == la_q);
        rd_word  = mem[LA];
`ifdef UBIT_PARITY_EN
        wr_word  = {^new_bits, new_bits};
        par_err  = rd_en && !bypass && (rd_word[2] != (rd_word[1] ^ rd_word[0]));
`else
        wr_word  = new_bits;
        par_err  = 1'b0;
`endif
    end

    // Array has no reset; its contents are defined only by the clear walk.
    always_ff @(posedge CLK) begin
        if (state == CLEAR)
            mem[cnt[ADDR_W-1:0]] <= '0;
        else if (wr_en)
            mem[la_q] <= wr_word;
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state <= CLEAR;
            cnt   <= '0;
            la_q  <= '0;
            OUBI  <= 1'b0;
            OUBD  <= 1'b0;
            BUSY  <= 1'b1;
            PERR  <= 1'b0;
        end else begin
            PERR <= 1'b0;
            case (state)
                IDLE: begin
                    if (FLUSH) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        BUSY  <= 1'b1;
                        OUBI  <= 1'b0;
                        OUBD  <= 1'b0;
                    end else if (rd_en) begin
                        la_q         <= LA;
                        {OUBI, OUBD} <= bypass ? new_bits : rd_word[1:0];
                        PERR         <= par_err;
                    end
                end
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == {1'b0, {ADDR_W{1'b1}}}) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                    BUSY  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/ubit_store.md
UBIT_STORE -- requirements
Module: ubit_store

Interface
REQ-001 Parameter ADDR_W, default 8, cache line index width; the store holds 2^ADDR_W entries.
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 RESET_n  input  1  reset, asynchronous, active-low.
REQ-004 LA  input  ADDR_W  cache line index for lookup.
REQ-005 LOOKUP  input  1  start a used-bit read of entry LA.
REQ-006 NUBI_n  input  1  new instruction used bit, active-low.
REQ-007 NUBD_n  input  1  new data used bit, active-low.
REQ-008 WCA_n  input  1  write-cycle-allowed strobe, active-low; commits new bits.
REQ-009 FLUSH  input  1  request to clear all entries.
REQ-010 OUBI  output  1  old instruction used bit of the last looked-up entry.
REQ-011 OUBD  output  1  old data used bit of the last looked-up entry.
REQ-012 BUSY  output  1  flush sequence in progress.
REQ-013 PERR  output  1  used-bit parity error, one-cycle pulse.

Function
REQ-014 The block SHALL have two states: IDLE and CLEAR.
REQ-015 Lookup in IDLE: LOOKUP=1 at edge N SHALL latch LA into LA_Q and drive OUBI/OUBD = entry[LA] after edge N (latency 1); OUBI/OUBD SHALL hold until the next lookup.
REQ-016 Write in IDLE: WCA_n=0 at an edge SHALL store {~NUBI_n, ~NUBD_n} into entry[LA_Q].
REQ-017 Simultaneous LOOKUP and write with LA==LA_Q SHALL return the newly written bits (write-before-read bypass); with LA!=LA_Q both proceed independently.
REQ-018 FLUSH=1 in IDLE SHALL enter CLEAR with counter=0; FLUSH takes priority over LOOKUP and write in the same cycle.
REQ-019 CLEAR SHALL zero entry[counter] each cycle, incrementing the counter, for exactly 2^ADDR_W cycles, then return to IDLE.
REQ-020 BUSY SHALL be 1 in every cycle the state is CLEAR and 0 in IDLE.
REQ-021 In CLEAR, LOOKUP, WCA_n and further FLUSH SHALL be ignored (no restart), and OUBI/OUBD SHALL be driven 0.
REQ-022 The counter SHALL be ADDR_W+1 bits wide, and its terminal value SHALL be all ones in the low ADDR_W bits, so no wrap occurs before exit.

Reset
REQ-023 RESET_n=0 SHALL immediately force OUBI=0, OUBD=0, PERR=0, LA_Q=0 and counter=0, and set the state to CLEAR (BUSY=1).
REQ-024 After RESET_n deasserts, the block SHALL complete a full clear of 2^ADDR_W cycles before accepting any lookup.
REQ-025 Reset asserted mid-CLEAR or mid-lookup SHALL restart the clear from index 0.
REQ-026 Array contents SHALL NOT be asynchronously reset; they are defined only by the clear sequence.

Configuration
REQ-027 With UBIT_PARITY_EN defined, each entry SHALL store a parity bit equal to used_i XOR used_d, and flush SHALL write parity 0.
REQ-028 With UBIT_PARITY_EN defined, a lookup whose stored parity mismatches SHALL pulse PERR=1 for one cycle aligned with the OUBI/OUBD update, while the bits are still presented.
REQ-029 With UBIT_PARITY_EN undefined, no parity storage SHALL exist and PERR SHALL be constant 0.

Verification
REQ-030 Reset, then hold LOOKUP=0 -> BUSY=1 for exactly 256 cycles after release, then 0; OUBI=OUBD=0.
REQ-031 LOOKUP, LA=0x05 -> next cycle OUBI=0, OUBD=0; then WCA_n=0 with NUBI_n=0, NUBD_n=1 -> re-lookup of 0x05 gives OUBI=1, OUBD=0.
REQ-032 Write to LA_Q=0x10 with LOOKUP at LA=0x10 in the same cycle, NUBD_n=0 -> next cycle OUBD=1 (bypass); the same test with LA=0x11 gives OUBD equal to entry 0x11.
REQ-033 Set entries 0x00 and 0xFF, FLUSH=1 together with LOOKUP=1 -> CLEAR entered, lookup ignored, BUSY for 256 cycles, both entries read 0 afterwards; a FLUSH pulse at cycle 100 of the clear does not extend BUSY.
REQ-034 RESET_n pulsed low at cycle 50 of the clear -> outputs 0 immediately, clear restarts, BUSY lasts 256 cycles from release.
REQ-035 With UBIT_PARITY_EN: force stored parity of entry 0x20 wrong -> lookup 0x20 gives PERR=1 for exactly one cycle; without the macro, PERR stays 0.
